mod997_chunk_reducer: RTL and testbench

Sequential controller that reduces a wide operand modulo 997. It time-shares one external 6-input residue LUT bank across the operand's 6-bit chunks, one chunk per cycle. The bank is the family of 6-in/10-out LUT blocks: lut_out = (chunk << CHUNK_W*sel) mod MODULUS. The block accumulates the partial residues with a modular adder and returns the final 10-bit residue over a valid/ready handshake. It sits between the operand source and downstream modular arithmetic in the mod_997 calculator.

---
 rtl/mod997_chunk_reducer_if.sv | 37 +++
 rtl/mod997_chunk_reducer.sv | 98 +++++++++
 tb/tb_mod997_chunk_reducer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mod997_chunk_reducer_if.sv
`default_nettype none
// ============================================================================
// Module      : mod997_chunk_reducer_if
// Description : Operand/result handshakes and residue-LUT bank bus for the
//               mod-997 chunk reducer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod997_chunk_reducer_if #(
    parameter int N_CHUNKS = 4,
    parameter int CHUNK_W  = 6,
    parameter int RES_W    = 10
);
    localparam int c_SEL_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    logic                          in_valid;
    logic                          in_ready;
    logic [CHUNK_W*N_CHUNKS-1:0]   in_operand;
    logic [c_SEL_W-1:0]            lut_sel;
    logic [CHUNK_W-1:0]            lut_in;
    logic [RES_W-1:0]              lut_out;
    logic                          out_valid;
    logic                          out_ready;
    logic [RES_W-1:0]              out_residue;
    logic                          out_err;

    // master = the reducer, slave = operand source / LUT bank / consumer
    modport master (
        input  in_valid, in_operand, lut_out, out_ready,
        output in_ready, lut_sel, lut_in, out_valid, out_residue, out_err
    );

    modport slave (
        output in_valid, in_operand, lut_out, out_ready,
        input  in_ready, lut_sel, lut_in, out_valid, out_residue, out_err
    );
endinterface
`default_nettype wire

// File: rtl/mod997_chunk_reducer.sv
`default_nettype none
// ============================================================================
// Module      : mod997_chunk_reducer
// Description : Reduces a wide operand modulo MODULUS one chunk per cycle using
//               a shared external residue LUT bank and a modular accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module mod997_chunk_reducer #(
    parameter int N_CHUNKS = 4,
    parameter int CHUNK_W  = 6,
    parameter int RES_W    = 10,
    parameter int MODULUS  = 997
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mod997_chunk_reducer_if.master  bus,
    output logic                    busy
);
    localparam int                 c_SEL_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int                 c_OP_W  = CHUNK_W * N_CHUNKS;
    localparam logic [RES_W:0]     c_MOD   = (RES_W+1)'(MODULUS);
    localparam logic [c_SEL_W-1:0] c_LAST  = c_SEL_W'(N_CHUNKS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [c_OP_W-1:0]   r_operand;
    logic [RES_W-1:0]    r_acc;
    logic [c_SEL_W-1:0]  r_cnt;
    logic                r_err;

    logic [CHUNK_W-1:0]  w_chunk;
    logic [RES_W:0]      w_sum;
    logic [RES_W-1:0]    w_acc_next;
    logic                w_lut_bad;
    logic                w_run;
    logic                w_done;

    assign w_run   = (r_state == c_RUN);
    assign w_done  = (r_state == c_DONE);
    assign w_chunk = r_operand[CHUNK_W*r_cnt +: CHUNK_W];

    // acc < MODULUS and lut_out < MODULUS keep sum below 2*MODULUS, so one
    // conditional subtract is enough.
    assign w_sum      = {1'b0, r_acc} + {1'b0, bus.lut_out};
    assign w_acc_next = RES_W'((w_sum >= c_MOD) ? (w_sum - c_MOD) : w_sum);
    assign w_lut_bad  = ({1'b0, bus.lut_out} >= c_MOD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_operand <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_operand <= bus.in_operand;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        r_state   <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_acc <= w_acc_next;
                    if (w_lut_bad) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == c_IDLE);
    assign bus.lut_sel     = w_run ? r_cnt : '0;
    assign bus.lut_in      = w_run ? w_chunk : '0;
    assign bus.out_valid   = w_done;
    assign bus.out_residue = w_done ? r_acc : '0;
    assign bus.out_err     = w_done & r_err;
    assign busy            = w_run | w_done;
endmodule
`default_nettype wire

// File: tb/tb_mod997_chunk_reducer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod997_chunk_reducer
// Description : Directed and random stimulus for mod997_chunk_reducer with a
//               behavioural residue LUT bank and arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod997_chunk_reducer;
    localparam int c_N   = 4;
    localparam int c_CW  = 6;
    localparam int c_RW  = 10;
    localparam int c_MOD = 997;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    bit   fault_en = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    mod997_chunk_reducer_if #(.N_CHUNKS(c_N), .CHUNK_W(c_CW), .RES_W(c_RW)) bus ();

    mod997_chunk_reducer #(
        .N_CHUNKS(c_N), .CHUNK_W(c_CW), .RES_W(c_RW), .MODULUS(c_MOD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.master),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lut_model(input int sel, input int v);
        return (v << (c_CW * sel)) % c_MOD;
    endfunction

    assign bus.lut_out = (fault_en && bus.lut_sel == 2'd2) ? 10'd1000
                         : 10'(lut_model(int'(bus.lut_sel), int'(bus.lut_in)));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [23:0] op, output int t);
        int g;
        g = 0;
        bus.in_valid   = 1'b1;
        bus.in_operand = op;
        while (!bus.in_ready && g < 50) begin
            step();
            g++;
        end
        check("accept_ready", 32'(bus.in_ready), 1);
        step();
        t = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input logic [23:0] op);
        int t, lat;
        accept(op, t);
        wait_result(lat);
        check("latency", lat, c_N);
        check("residue", 32'(bus.out_residue), int'(op) % c_MOD);
        check("err", 32'(bus.out_err), 0);
        bus.out_ready = 1'b1;
        step();
        check("idle_after_hs", 32'({bus.in_ready, bus.out_valid}), 32'b10);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, lat, prev_t, sum;
        logic [23:0] op, op2;
        logic [23:0] ops [5];
        logic [23:0] dir [6];
        bit seen;

        bus.in_valid   = 1'b0;
        bus.in_operand = '0;
        bus.out_ready  = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_residue", 32'(bus.out_residue), 0);
        check("rst_err", 32'(bus.out_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_lut", 32'({bus.lut_sel, bus.lut_in}), 0);
        rst = 1'b0;

        // Basic directed values
        dir = '{24'd1, 24'd64, 24'd996, 24'd997, 24'd1994, 24'hFFFFFF};
        foreach (dir[i]) run_op(dir[i]);

        // Random operands
        for (int i = 0; i < 8; i++) run_op(24'($urandom));

        // Chunk sequencing
        op = 24'h00FC41;
        accept(op, t);
        for (int k = 0; k < c_N; k++) begin
            check("seq_sel", 32'(bus.lut_sel), k);
            check("seq_in", 32'(bus.lut_in), (int'(op) >> (c_CW * k)) & 63);
            step();
        end
        check("seq_valid", 32'(bus.out_valid), 1);
        check("seq_residue", 32'(bus.out_residue), int'(op) % c_MOD);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Reset in the middle of an operation
        accept(24'hFFFFFF, t);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(bus.in_ready), 1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_residue", 32'(bus.out_residue), 0);
        check("mid_rst_busy", 32'(busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen |= bus.out_valid | busy;
        end
        check("mid_rst_no_result", 32'(seen), 0);

        // Back-pressure with a pending operand
        op  = 24'($urandom);
        op2 = 24'($urandom);
        accept(op, t);
        wait_result(lat);
        check("bp_latency", lat, c_N);
        bus.in_valid   = 1'b1;
        bus.in_operand = op2;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_residue", 32'(bus.out_residue), int'(op) % c_MOD);
            check("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_release_idle", 32'({bus.in_ready, bus.out_valid}), 32'b10);
        step();
        bus.in_valid = 1'b0;
        check("bp_pending_accepted", 32'({busy, bus.in_ready}), 32'b10);
        wait_result(lat);
        check("bp2_latency", lat, c_N);
        check("bp2_residue", 32'(bus.out_residue), int'(op2) % c_MOD);
        bus.out_ready = 1'b1;
        step();

        // Back-to-back stream with out_ready held high
        foreach (ops[i]) ops[i] = 24'($urandom);
        prev_t = 0;
        foreach (ops[i]) begin
            accept(ops[i], t);
            if (i > 0) check("b2b_period", t - prev_t, c_N + 2);
            prev_t = t;
            wait_result(lat);
            check("b2b_residue", 32'(bus.out_residue), int'(ops[i]) % c_MOD);
        end
        step();
        bus.out_ready = 1'b0;

        // LUT fault on chunk 2: residue stays congruent to the faulty term sum
        op = 24'h123456;
        sum = 0;
        for (int k = 0; k < c_N; k++)
            sum += (k == 2) ? 1000 : lut_model(k, (int'(op) >> (c_CW * k)) & 63);
        fault_en = 1'b1;
        accept(op, t);
        wait_result(lat);
        fault_en = 1'b0;
        check("fault_latency", lat, c_N);
        check("fault_err", 32'(bus.out_err), 1);
        check("fault_residue_cong", 32'(int'(bus.out_residue) % c_MOD), sum % c_MOD);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        run_op(24'h123456);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
